// File: rtl/rice_param_argmin.sv
// rice_param_argmin: registered argmin tree over NUM_IN masked unsigned costs.
// Lower index wins ties; an all-masked request reports index 0, cost all-ones.
module rice_param_argmin #(
  parameter int NUM_IN = 15,
  parameter int WIDTH  = 32,
  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int LEVELS = IDX_W
) (
  input  logic                    iClock,
  input  logic                    iReset_n,
  input  logic                    iEnable,
  input  logic                    iValid,
  input  logic [NUM_IN*WIDTH-1:0] iIn,
  input  logic [NUM_IN-1:0]       iMask,
  output logic                    oValid,
  output logic [IDX_W-1:0]        oMinimum,
  output logic [WIDTH-1:0]        oSum,
  output logic                    oAllMasked
);

  function automatic int f_cnt(input int lvl);
    return (NUM_IN + (1 << lvl) - 1) >> lvl;
  endfunction

  logic             r_out_vld;
  logic [IDX_W-1:0] r_out_min;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_all;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lv
    localparam int PN = f_cnt(l - 1);
    localparam int NN = f_cnt(l);

    logic             w_pv;
    logic [PN-1:0]    w_pl;
    logic [IDX_W-1:0] w_pi [PN];
    logic [WIDTH-1:0] w_pc [PN];
    logic [NN-1:0]    w_nl;
    logic [IDX_W-1:0] w_ni [NN];
    logic [WIDTH-1:0] w_nc [NN];

    if (l == 1) begin : g_src
      always_comb begin
        w_pv = iValid;
        w_pl = {PN{iValid}} & ~iMask;
        for (int k = 0; k < PN; k++) begin
          w_pi[k] = IDX_W'(k);
          w_pc[k] = iIn[k*WIDTH +: WIDTH];
        end
      end
    end else begin : g_src
      always_comb begin
        w_pv = g_lv[l-1].g_reg.r_vld;
        w_pl = g_lv[l-1].g_reg.r_live;
        w_pi = g_lv[l-1].g_reg.r_idx;
        w_pc = g_lv[l-1].g_reg.r_cost;
      end
    end

    for (genvar j = 0; j < NN; j++) begin : g_node
      if (2*j + 1 < PN) begin : g_pair
        // B only beats A when strictly cheaper, so ties keep the lower index
        logic w_take_b;
        assign w_take_b = w_pl[2*j+1] &
                          (~w_pl[2*j] | (w_pc[2*j+1] < w_pc[2*j]));
        assign w_nl[j] = w_pl[2*j] | w_pl[2*j+1];
        assign w_ni[j] = w_take_b ? w_pi[2*j+1] : w_pi[2*j];
        assign w_nc[j] = w_take_b ? w_pc[2*j+1] : w_pc[2*j];
      end else begin : g_pass
        assign w_nl[j] = w_pl[2*j];
        assign w_ni[j] = w_pi[2*j];
        assign w_nc[j] = w_pc[2*j];
      end
    end

    if (l < LEVELS) begin : g_reg
      logic             r_vld;
      logic [NN-1:0]    r_live;
      logic [IDX_W-1:0] r_idx  [NN];
      logic [WIDTH-1:0] r_cost [NN];

      always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
          r_vld  <= 1'b0;
          r_live <= '0;
          for (int k = 0; k < NN; k++) begin
            r_idx[k]  <= '0;
            r_cost[k] <= '0;
          end
        end else if (iEnable) begin
          r_vld  <= w_pv;
          r_live <= w_nl;
          r_idx  <= w_ni;
          r_cost <= w_nc;
        end
      end
    end else begin : g_out
      // result fields only move with a valid request; otherwise they hold
      always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
          r_out_vld <= 1'b0;
          r_out_min <= '0;
          r_out_sum <= '0;
          r_out_all <= 1'b0;
        end else if (iEnable) begin
          r_out_vld <= w_pv;
          if (w_pv) begin
            r_out_all <= ~w_nl[0];
            r_out_min <= w_nl[0] ? w_ni[0] : '0;
            r_out_sum <= w_nl[0] ? w_nc[0] : '1;
          end
        end
      end
    end
  end

  assign oValid     = r_out_vld;
  assign oMinimum   = r_out_min;
  assign oSum       = r_out_sum;
  assign oAllMasked = r_out_all;

endmodule
